// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired controller: opcode values, IR field
// positions, state encodings and opcode classification.
package control_unit_pkg;

  localparam int NREG = 16;
  localparam int OPW  = 5;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_BINARY,
    CLS_UNARY,
    CLS_HALT
  } op_class_t;

  // Unlisted opcodes fall into CLS_NOP so they simply refetch.
  function automatic op_class_t classify(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV: return CLS_BINARY;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_NOP;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// instruction/memory status in, bus-drive and load strobes out.
interface control_unit_if;
  import control_unit_pkg::*;

  logic [31:0]     IR;
  logic            mem_ready;
  logic            PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic            IncPC;
  logic            Read;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic [OPW-1:0]  opcode;
  logic            run;

  modport master (
    input  IR, mem_ready,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Rin, Rout, opcode, run
  );

  modport slave (
    output IR, mem_ready,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Rin, Rout, opcode, run
  );
endinterface

// File: rtl/control_unit_reg_select.sv
// Register-field decoder: 4-bit register number plus enable to a one-hot
// general-register strobe vector.
module control_unit_reg_select
  import control_unit_pkg::*;
(
  input  logic [3:0]      field,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch, decode and T-state execution of
// register-register, mul/div and unary instructions.
//
// state | meaning
// RST   | just reset, no strobes
// T0    | PC onto bus, MAR load, ALU computes PC+1 into Z
// T1    | Z low back into PC
// T2    | memory read into MDR, wait for mem_ready
// T3    | MDR into IR
// T4    | decode; first operand to Y (binary) or unary ALU op into Z
// T5    | second operand, binary ALU op into Z
// T6    | Z low to Ra, or to LO for mul/div
// T7    | Z high to HI (mul/div only)
// HALT  | stopped, run=0 until reset
module control_unit
  import control_unit_pkg::*;
(
  input  logic           Clock,
  input  logic           clear_n,
  control_unit_if.master bus
);

  state_t          state, state_nxt;
  logic [OPW-1:0]  op;
  logic [3:0]      ra, rb, rc;
  op_class_t       op_cls;
  logic            rin_en, rout_en;
  logic [3:0]      rout_field;
  logic            unused_ir_bits;

  assign op     = bus.IR[OP_MSB:OP_LSB];
  assign ra     = bus.IR[RA_MSB:RA_LSB];
  assign rb     = bus.IR[RB_MSB:RB_LSB];
  assign rc     = bus.IR[RC_MSB:RC_LSB];
  assign op_cls = classify(op);
  assign unused_ir_bits = ^bus.IR[RC_LSB-1:0];

  always_ff @(posedge Clock) begin
    if (!clear_n) state <= ST_RST;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.PCout    = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.MDRout   = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.opcode   = '0;
    bus.run      = 1'b1;
    rin_en       = 1'b0;
    rout_en      = 1'b0;
    rout_field   = rb;
    case (state)
      ST_RST: state_nxt = ST_T0;
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_nxt = ST_T1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        state_nxt   = ST_T2;
      end
      ST_T2: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (bus.mem_ready) state_nxt = ST_T3;
      end
      ST_T3: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_nxt  = ST_T4;
      end
      ST_T4: begin
        case (op_cls)
          CLS_BINARY: begin
            rout_en   = 1'b1;
            bus.Yin   = 1'b1;
            state_nxt = ST_T5;
          end
          CLS_UNARY: begin
            rout_en    = 1'b1;
            bus.Zin    = 1'b1;
            bus.opcode = op;
            state_nxt  = ST_T6;
          end
          CLS_HALT: state_nxt = ST_HALT;
          default:  state_nxt = ST_T0;
        endcase
      end
      ST_T5: begin
        rout_field = rc;
        rout_en    = 1'b1;
        bus.Zin    = 1'b1;
        bus.opcode = op;
        state_nxt  = ST_T6;
      end
      ST_T6: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv(op)) begin
          bus.LOin  = 1'b1;
          state_nxt = ST_T7;
        end else begin
          rin_en    = 1'b1;
          state_nxt = ST_T0;
        end
      end
      ST_T7: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        state_nxt    = ST_T0;
      end
      ST_HALT: bus.run = 1'b0;
      default: state_nxt = ST_RST;
    endcase
  end

  control_unit_reg_select u_rin_sel (
    .field  (ra),
    .en     (rin_en),
    .onehot (bus.Rin)
  );

  control_unit_reg_select u_rout_sel (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (bus.Rout)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each scenario queues per-cycle stimulus
// with the expected strobe vector, then drains the queue against the DUT.
module tb_control_unit;
  import control_unit_pkg::*;

  logic Clock = 1'b0;
  logic clear_n;

  control_unit_if bus ();

  control_unit dut (
    .Clock   (Clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  localparam logic [15:0] S_PCOUT  = 16'h0001;
  localparam logic [15:0] S_ZHI    = 16'h0002;
  localparam logic [15:0] S_ZLO    = 16'h0004;
  localparam logic [15:0] S_MDROUT = 16'h0008;
  localparam logic [15:0] S_PCIN   = 16'h0040;
  localparam logic [15:0] S_IRIN   = 16'h0080;
  localparam logic [15:0] S_MARIN  = 16'h0100;
  localparam logic [15:0] S_MDRIN  = 16'h0200;
  localparam logic [15:0] S_YIN    = 16'h0400;
  localparam logic [15:0] S_ZIN    = 16'h0800;
  localparam logic [15:0] S_HIIN   = 16'h1000;
  localparam logic [15:0] S_LOIN   = 16'h2000;
  localparam logic [15:0] S_INC    = 16'h4000;
  localparam logic [15:0] S_READ   = 16'h8000;

  typedef struct {
    logic [53:0] exp;
    logic        mr;
    logic        cn;
    logic [31:0] ir;
    string       tag;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int total = 0;
  int bad   = 0;

  function automatic logic [53:0] obs();
    return {bus.Read, bus.IncPC, bus.LOin, bus.HIin, bus.Zin, bus.Yin, bus.MDRin,
            bus.MARin, bus.IRin, bus.PCin, bus.LOout, bus.HIout, bus.MDRout,
            bus.Zlowout, bus.Zhighout, bus.PCout, bus.Rin, bus.Rout, bus.opcode, bus.run};
  endfunction

  function automatic logic [53:0] ev(input logic [15:0] s, input logic [15:0] rin,
                                     input logic [15:0] rout, input logic [4:0] opc,
                                     input logic run);
    return {s, rin, rout, opc, run};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] f);
    return 16'(1) << f;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [53:0] x, input logic mr, input logic cn,
                      input logic [31:0] ir, input string tag);
    ent_t n;
    n.exp = x; n.mr = mr; n.cn = cn; n.ir = ir; n.tag = tag;
    sb.push_back(n);
  endtask

  // Fetch T0..T3 with garbage on IR; optional reset on the last stall cycle.
  task automatic push_fetch(input string nm, input int stalls, input bit abort);
    push(ev(S_PCOUT | S_MARIN | S_INC | S_ZIN, 0, 0, 0, 1), rnd(), 1, $urandom, {nm, ".T0"});
    push(ev(S_ZLO | S_PCIN, 0, 0, 0, 1), rnd(), 1, $urandom, {nm, ".T1"});
    for (int i = 0; i <= stalls; i++) begin
      if (abort && i == stalls) begin
        push(ev(S_READ | S_MDRIN, 0, 0, 0, 1), 1'b0, 1'b0, $urandom, {nm, ".T2rst"});
        push(ev(0, 0, 0, 0, 1), rnd(), 1, $urandom, {nm, ".RST"});
        return;
      end
      push(ev(S_READ | S_MDRIN, 0, 0, 0, 1), (i == stalls), 1, $urandom, {nm, ".T2"});
    end
    push(ev(S_MDROUT | S_IRIN, 0, 0, 0, 1), rnd(), 1, $urandom, {nm, ".T3"});
  endtask

  // Execute phase derived from the opcode table; optional reset during T5.
  task automatic push_exec(input string nm, input logic [31:0] ir, input bit rst_t5);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit bin, un, md;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    bin = (op >= 5'b00011 && op <= 5'b01011) || op == 5'b01111 || op == 5'b10000;
    un  = (op == 5'b10001) || (op == 5'b10010);
    md  = (op == 5'b01111) || (op == 5'b10000);
    if (bin) push(ev(S_YIN, 0, oh(rb), 0, 1), rnd(), 1, ir, {nm, ".T4"});
    else if (un) push(ev(S_ZIN, 0, oh(rb), op, 1), rnd(), 1, ir, {nm, ".T4"});
    else begin
      push(ev(0, 0, 0, 0, 1), rnd(), 1, ir, {nm, ".T4"});
      return;
    end
    if (bin) begin
      push(ev(S_ZIN, 0, oh(rc), op, 1), rnd(), !rst_t5, ir, {nm, ".T5"});
      if (rst_t5) begin
        push(ev(0, 0, 0, 0, 1), rnd(), 1, ir, {nm, ".RST"});
        return;
      end
    end
    if (md) begin
      push(ev(S_ZLO | S_LOIN, 0, 0, 0, 1), rnd(), 1, ir, {nm, ".T6"});
      push(ev(S_ZHI | S_HIIN, 0, 0, 0, 1), rnd(), 1, ir, {nm, ".T7"});
    end else begin
      push(ev(S_ZLO, oh(ra), 0, 0, 1), rnd(), 1, ir, {nm, ".T6"});
    end
  endtask

  task automatic test_reset();
    push(ev(0, 0, 0, 0, 1), 1, 0, 0, "reset.hold");
    push(ev(0, 0, 0, 0, 1), 1, 1, 0, "reset.release");
    push(ev(S_PCOUT | S_MARIN | S_INC | S_ZIN, 0, 0, 0, 1), 1, 0, 0, "reset.T0");
    push(ev(0, 0, 0, 0, 1), 1, 1, 0, "reset.again");
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_and();
    push_fetch("and", 0, 0);
    push_exec("and", 32'h28918000, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_shra_stall();
    push_fetch("shra", 3, 0);
    push_exec("shra", 32'h40918000, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_mul();
    push_fetch("mul", 1, 0);
    push_exec("mul", 32'h78990000, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [6];
    prog = '{32'hD0000000, 32'h00000000, 32'h88900000, 32'h93A50000,
             32'h1FFF8000, 32'h96C00000};
    for (int i = 0; i < 6; i++) begin
      push_fetch($sformatf("b2b%0d", i), i % 3, 0);
      push_exec($sformatf("b2b%0d", i), prog[i], 0);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_halt();
    push_fetch("halt", 0, 0);
    push_exec("halt", 32'hD8000000, 0);
    for (int i = 0; i < 20; i++) push(ev(0, 0, 0, 0, 0), rnd(), 1, $urandom, "halt.HALT");
    push(ev(0, 0, 0, 0, 0), rnd(), 0, $urandom, "halt.clear");
    push(ev(0, 0, 0, 0, 1), rnd(), 1, $urandom, "halt.RST");
    push_fetch("resume", 0, 0);
    push_exec("resume", 32'h18918000, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    push_fetch("rst5", 0, 0);
    push_exec("rst5", 32'h28918000, 1);
    push_fetch("rst2", 2, 1);
    push_fetch("after", 0, 0);
    push_exec("after", 32'h20918000, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      bus.IR = e.ir; bus.mem_ready = e.mr; clear_n = e.cn; #1;
      total++;
      if (obs() !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.tag, obs(), e.exp); end
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    clear_n = 1'b0;
    bus.IR = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    test_and();
    test_shra_stall();
    test_mul();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
